ifu_cache: RTL and testbench
============================

# ifu_cache

Fully associative instruction-line cache between the instruction fetch unit (CPU side) and instruction memory. Each cycle it looks up the tag of the fetch address. On a hit it returns the stored 128-bit line one cycle later. On a miss it raises a tag request toward memory and allocates memory fill responses into a tag/line array.

## Interface
- NUM_TAGS, 16: number of entries (tag storage); must equal NUM_LINES.
- NUM_LINES, 16: number of line storage entries.
- TAG_WIDTH, 27: tag width; equals ADDR_WIDTH - OFFSET_WIDTH.
- LINE_WIDTH, 128: instruction line width in bits.
- ADDR_WIDTH, 32: CPU address width.
- OFFSET_WIDTH, 5: low address bits ignored for lookup.

Ports:
- Clock  in  1  single clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- cpu_reqAddrIn  in  ADDR_WIDTH  fetch address, sampled every cycle.
- cpu_rspAddrOut  out  ADDR_WIDTH  address whose line is returned.
- cpu_rspInsLineOut  out  LINE_WIDTH  returned instruction line.
- cpu_rspInsLineValidOut  out  1  response valid (hit).
- mem_rspTagIn  in  TAG_WIDTH  tag of the fill line.
- mem_rspInsLineIn  in  LINE_WIDTH  fill line data.
- mem_rspInsLineValidIn  in  1  fill valid, one write per asserted cycle.
- mem_reqTagOut  out  TAG_WIDTH  missing tag requested from memory.
- mem_reqTagValidOut  out  1  miss request valid.
- dataInsertion  out  1  a new entry was allocated on the previous edge.

## Operation
- Request tag = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH]. Combinational compare against all valid entries. Entries are unique, so at most one matches.
- Hit: register the address and the matching line, and set the valid output. Clear mem_reqTagValidOut.
- Miss: clear cpu_rspInsLineValidOut; hold cpu_rspAddrOut and cpu_rspInsLineOut at their last values. Set mem_reqTagValidOut and set mem_reqTagOut to the request tag.
- Fill, when mem_rspInsLineValidIn=1:
  - If mem_rspTagIn already resides in the array, overwrite that entry's line and leave dataInsertion at 0.
  - Otherwise allocate a victim, write the tag, line and valid bit, and set dataInsertion to 1 for one cycle.
- Victim selection: the lowest-index invalid entry. If all entries are valid, use a round-robin pointer, then increment it modulo NUM_LINES (FIFO replacement).
- Memory holds requests; the cache does not track outstanding misses. A fill for any tag is accepted at any time.

## Timing
- All outputs are registered.
- Hit latency: one cycle. An address applied before edge N produces a response valid after edge N.
- A fill written at edge N is visible to lookup from edge N+1. A hit on that line is therefore reported after edge N+1 (without bypass).
- Simultaneous lookup and fill of the same tag: the lookup reports a miss this cycle unless bypass is enabled (see Configuration).
- Reset (asynchronous, any time including mid-fill):
  - All valid bits cleared and the round-robin pointer set to 0.
  - All outputs go to 0.
  - A fill in flight is discarded.
- The array has no empty or full flag. When full, replacement wraps through the pointer.

## Configuration
- IFU_CACHE_FILL_BYPASS_EN defined: when a fill's tag equals the current request tag, the fill data is forwarded directly. The response is valid at the same edge as the write, with cpu_rspInsLineOut = mem_rspInsLineIn, and mem_reqTagValidOut clears.
- IFU_CACHE_FILL_BYPASS_EN undefined: no forwarding; the hit is reported one cycle after the write.

## Test plan
- Reset, then request 0x00000000 with no fill: valid=0, mem_reqTagValidOut=1, mem_reqTagOut=0x0000000. All outputs are 0 during reset.
- Fill tag 0x0000000 with line 0xDEADBEEF×4, fill valid for one cycle: dataInsertion=1 for one cycle. Next cycle, request 0x0000001C returns that line with valid=1 and cpu_rspAddrOut=0x0000001C.
- Hold the fill valid for 3 cycles with tag 0x0000001 and data 0xCAFEBABE×4: dataInsertion=1 only on the first cycle. A request to 0x00000020 then hits with the CAFEBABE line.
- Fill 17 distinct tags 0x10 to 0x20: the 17th replaces entry 0. Tag 0x10 then misses and tag 0x11 hits.
- Same-cycle fill and request, tag 0x0000003, line 0xFEEDC0DE×4: a hit the same edge with IFU_CACHE_FILL_BYPASS_EN, one edge later without it.
- Assert Rst low mid-operation after hits: valid bits are cleared, and re-requesting a previously cached address misses.

Source files
------------

// File: rtl/ifu_cache.sv
// rtl/ifu_cache.sv - fully associative instruction-line cache with FIFO replacement
// Optional same-cycle fill forwarding: IFU_CACHE_FILL_BYPASS_EN
module ifu_cache #(
  parameter int NUM_TAGS     = 16,
  parameter int NUM_LINES    = 16,
  parameter int TAG_WIDTH    = 27,
  parameter int LINE_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] cpu_reqAddrIn,
  output logic [ADDR_WIDTH-1:0] cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0] cpu_rspInsLineOut,
  output logic                  cpu_rspInsLineValidOut,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  input  logic                  mem_rspInsLineValidIn,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  output logic                  mem_reqTagValidOut,
  output logic                  dataInsertion
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  logic [NUM_TAGS-1:0]   r_valid;
  logic [TAG_WIDTH-1:0]  r_tag  [NUM_TAGS];
  logic [LINE_WIDTH-1:0] r_line [NUM_LINES];
  logic [IDX_W-1:0]      r_rr_ptr;

  logic [TAG_WIDTH-1:0]  w_req_tag;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_fill_match;
  logic [IDX_W-1:0]      w_fill_idx;
  logic                  w_has_free;
  logic [IDX_W-1:0]      w_free_idx;
  logic [IDX_W-1:0]      w_victim;
  logic                  w_bypass;
  logic [LINE_WIDTH-1:0] w_hit_line;

  assign w_req_tag = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH];

  // Descending scan so the lowest matching/free index wins.
  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_fill_match = 1'b0;
    w_fill_idx   = '0;
    w_has_free   = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (r_valid[i] && (r_tag[i] == mem_rspTagIn)) begin
        w_fill_match = 1'b1;
        w_fill_idx   = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_victim   = w_has_free ? w_free_idx : r_rr_ptr;
  assign w_hit_line = r_line[w_hit_idx];

`ifdef IFU_CACHE_FILL_BYPASS_EN
  assign w_bypass = mem_rspInsLineValidIn && (mem_rspTagIn == w_req_tag);
`else
  assign w_bypass = 1'b0;
`endif

  // Tag/line storage needs no reset; validity lives in r_valid.
  always_ff @(posedge Clock) begin
    if (Rst && mem_rspInsLineValidIn) begin
      if (w_fill_match) begin
        r_line[w_fill_idx] <= mem_rspInsLineIn;
      end else begin
        r_tag[w_victim]  <= mem_rspTagIn;
        r_line[w_victim] <= mem_rspInsLineIn;
      end
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_valid                <= '0;
      r_rr_ptr               <= '0;
      dataInsertion          <= 1'b0;
      cpu_rspAddrOut         <= '0;
      cpu_rspInsLineOut      <= '0;
      cpu_rspInsLineValidOut <= 1'b0;
      mem_reqTagOut          <= '0;
      mem_reqTagValidOut     <= 1'b0;
    end else begin
      dataInsertion <= 1'b0;
      if (mem_rspInsLineValidIn && !w_fill_match) begin
        r_valid[w_victim] <= 1'b1;
        dataInsertion     <= 1'b1;
        if (!w_has_free) begin
          if (r_rr_ptr == IDX_W'(NUM_LINES - 1)) r_rr_ptr <= '0;
          else                                   r_rr_ptr <= r_rr_ptr + 1'b1;
        end
      end

      if (w_hit || w_bypass) begin
        cpu_rspAddrOut         <= cpu_reqAddrIn;
        cpu_rspInsLineOut      <= w_bypass ? mem_rspInsLineIn : w_hit_line;
        cpu_rspInsLineValidOut <= 1'b1;
        mem_reqTagValidOut     <= 1'b0;
      end else begin
        cpu_rspInsLineValidOut <= 1'b0;
        mem_reqTagValidOut     <= 1'b1;
        mem_reqTagOut          <= w_req_tag;
      end
    end
  end

endmodule

// File: tb/tb_ifu_cache.sv
// tb/tb_ifu_cache.sv - self-checking bench for ifu_cache
module tb_ifu_cache;

  logic         Clock;
  logic         Rst;
  logic [31:0]  cpu_reqAddrIn;
  logic [31:0]  cpu_rspAddrOut;
  logic [127:0] cpu_rspInsLineOut;
  logic         cpu_rspInsLineValidOut;
  logic [26:0]  mem_rspTagIn;
  logic [127:0] mem_rspInsLineIn;
  logic         mem_rspInsLineValidIn;
  logic [26:0]  mem_reqTagOut;
  logic         mem_reqTagValidOut;
  logic         dataInsertion;

  ifu_cache dut (
    .Clock                  (Clock),
    .Rst                    (Rst),
    .cpu_reqAddrIn          (cpu_reqAddrIn),
    .cpu_rspAddrOut         (cpu_rspAddrOut),
    .cpu_rspInsLineOut      (cpu_rspInsLineOut),
    .cpu_rspInsLineValidOut (cpu_rspInsLineValidOut),
    .mem_rspTagIn           (mem_rspTagIn),
    .mem_rspInsLineIn       (mem_rspInsLineIn),
    .mem_rspInsLineValidIn  (mem_rspInsLineValidIn),
    .mem_reqTagOut          (mem_reqTagOut),
    .mem_reqTagValidOut     (mem_reqTagValidOut),
    .dataInsertion          (dataInsertion)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0]  addr;
    logic         fv;
    logic [26:0]  ftag;
    logic [127:0] fdata;
    logic         e_v;
    logic [127:0] e_line;
    logic         e_rq;
    logic [26:0]  e_rtag;
    logic         e_ins;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [127:0] L_DEAD = {4{32'hDEADBEEF}};
  localparam logic [127:0] L_CAFE = {4{32'hCAFEBABE}};
  localparam logic [127:0] L_FEED = {4{32'hFEEDC0DE}};

  function automatic vec_t mk(input logic [31:0] addr, input logic fv, input logic [26:0] ftag,
                              input logic [127:0] fdata, input logic e_v, input logic [127:0] e_line,
                              input logic e_rq, input logic [26:0] e_rtag, input logic e_ins);
    vec_t v;
    v.addr = addr; v.fv = fv; v.ftag = ftag; v.fdata = fdata;
    v.e_v = e_v; v.e_line = e_line; v.e_rq = e_rq; v.e_rtag = e_rtag; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input vec_t e);
    chk("rsp_valid", 128'(cpu_rspInsLineValidOut), 128'(e.e_v));
    if (e.e_v) begin
      chk("rsp_addr", 128'(cpu_rspAddrOut), 128'(e.addr));
      chk("rsp_line", cpu_rspInsLineOut, e.e_line);
    end
    chk("req_valid", 128'(mem_reqTagValidOut), 128'(e.e_rq));
    if (e.e_rq) chk("req_tag", 128'(mem_reqTagOut), 128'(e.e_rtag));
    chk("data_ins", 128'(dataInsertion), 128'(e.e_ins));
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge Clock);
    cpu_reqAddrIn         = v.addr;
    mem_rspInsLineValidIn = v.fv;
    mem_rspTagIn          = v.ftag;
    mem_rspInsLineIn      = v.fdata;
    sb.push_back(v);
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    cmp(e);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rsp_addr"},  128'(cpu_rspAddrOut), 128'h0);
    chk({nm, "_rsp_line"},  cpu_rspInsLineOut, 128'h0);
    chk({nm, "_rsp_valid"}, 128'(cpu_rspInsLineValidOut), 128'h0);
    chk({nm, "_req_tag"},   128'(mem_reqTagOut), 128'h0);
    chk({nm, "_req_valid"}, 128'(mem_reqTagValidOut), 128'h0);
    chk({nm, "_data_ins"},  128'(dataInsertion), 128'h0);
  endtask

  initial begin
    Rst                   = 1'b0;
    cpu_reqAddrIn         = '0;
    mem_rspTagIn          = '0;
    mem_rspInsLineIn      = '0;
    mem_rspInsLineValidIn = 1'b0;

    vecs.push_back(mk(32'h0000_0000, 0, 27'h0, '0,     0, '0,     1, 27'h0, 0));
    vecs.push_back(mk(32'h0000_0040, 1, 27'h0, L_DEAD, 0, '0,     1, 27'h2, 1));
    vecs.push_back(mk(32'h0000_001C, 0, 27'h0, '0,     1, L_DEAD, 0, 27'h0, 0));
    vecs.push_back(mk(32'h0000_0040, 1, 27'h1, L_CAFE, 0, '0,     1, 27'h2, 1));
    vecs.push_back(mk(32'h0000_0040, 1, 27'h1, L_CAFE, 0, '0,     1, 27'h2, 0));
    vecs.push_back(mk(32'h0000_0040, 1, 27'h1, L_CAFE, 0, '0,     1, 27'h2, 0));
    vecs.push_back(mk(32'h0000_0020, 0, 27'h0, '0,     1, L_CAFE, 0, 27'h0, 0));
`ifdef IFU_CACHE_FILL_BYPASS_EN
    vecs.push_back(mk(32'h0000_0060, 1, 27'h3, L_FEED, 1, L_FEED, 0, 27'h0, 1));
`else
    vecs.push_back(mk(32'h0000_0060, 1, 27'h3, L_FEED, 0, '0,     1, 27'h3, 1));
`endif
    vecs.push_back(mk(32'h0000_0060, 0, 27'h0, '0,     1, L_FEED, 0, 27'h0, 0));
    vecs.push_back(mk(32'h0000_0080, 0, 27'h0, '0,     0, '0,     1, 27'h4, 0));

    repeat (2) @(posedge Clock);
    #1;
    chk_all_zero("reset");
    @(negedge Clock);
    Rst = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // Asynchronous reset between edges while a fill is presented.
    @(negedge Clock);
    cpu_reqAddrIn         = 32'h0000_001C;
    mem_rspTagIn          = 27'h5;
    mem_rspInsLineIn      = L_FEED;
    mem_rspInsLineValidIn = 1'b1;
    #2 Rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge Clock);
    #1;
    chk_all_zero("rst_held");
    @(negedge Clock);
    Rst = 1'b1;
    mem_rspInsLineValidIn = 1'b0;
    step(mk(32'h0000_001C, 0, 27'h0, '0, 0, '0, 1, 27'h0, 0));
    step(mk(32'h0000_0020, 0, 27'h0, '0, 0, '0, 1, 27'h1, 0));
    step(mk(32'h0000_00A0, 0, 27'h0, '0, 0, '0, 1, 27'h5, 0));

    // 17 distinct fills into an empty array: the last wraps onto entry 0.
    for (int t = 16; t <= 32; t++)
      step(mk(32'h0000_0000, 1, 27'(t), {4{32'h1000_0000 | 32'(t)}}, 0, '0, 1, 27'h0, 1));
    step(mk(32'h0000_0200, 0, 27'h0, '0, 0, '0, 1, 27'h10, 0));
    step(mk(32'h0000_0220, 0, 27'h0, '0, 1, {4{32'h1000_0011}}, 0, 27'h0, 0));
    step(mk(32'h0000_0400, 0, 27'h0, '0, 1, {4{32'h1000_0020}}, 0, 27'h0, 0));
    step(mk(32'h0000_03FC, 0, 27'h0, '0, 1, {4{32'h1000_001F}}, 0, 27'h0, 0));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
